// File: rtl/muldiv_defs.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_defs (package)
//  Brief    : Shared constants and FSM encoding for the RV32M execute unit
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_defs;

  // funct3 (inst[14:12]) operation select
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Instruction class identifiers for the M extension
  localparam logic [6:0] OPC_RCC       = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Control FSM encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : execute_muldiv_if
//  Brief    : Pipeline <-> mul/div unit signal bundle
//  Revision : 1.0 - initial release
// ============================================================================
interface execute_muldiv_if #(
  parameter int XLEN = 32
);
  logic            MD_start;
  logic [2:0]      MD_funct3;
  logic [XLEN-1:0] MD_rs1;
  logic [XLEN-1:0] MD_rs2;
  logic [4:0]      MD_rd;
  logic            MD_flush;
  logic            MD_stall;
  logic            MD_valid;
  logic [XLEN-1:0] MD_result;
  logic [4:0]      MD_rd_out;

  // Pipeline side: issues operations, observes stall/result
  modport master (
    output MD_start, MD_funct3, MD_rs1, MD_rs2, MD_rd, MD_flush,
    input  MD_stall, MD_valid, MD_result, MD_rd_out
  );

  // Unit side
  modport slave (
    input  MD_start, MD_funct3, MD_rs1, MD_rs2, MD_rd, MD_flush,
    output MD_stall, MD_valid, MD_result, MD_rd_out
  );
endinterface
`default_nettype wire

// File: rtl/div_serial.sv
`default_nettype none
// ============================================================================
//  Module   : div_serial
//  Brief    : Radix-2 restoring unsigned divider, one quotient bit per cycle
//  Revision : 1.0 - initial release
// ============================================================================
module div_serial #(
  parameter int XLEN = 32
) (
  input  wire logic            CLK,
  input  wire logic            RES,
  input  wire logic            i_start,
  input  wire logic            i_abort,
  input  wire logic [XLEN-1:0] i_dividend,
  input  wire logic [XLEN-1:0] i_divisor,
  output logic                 o_done,
  output logic [XLEN-1:0]      o_quot,
  output logic [XLEN-1:0]      o_rem
);
  localparam int              CW     = $clog2(XLEN);
  localparam logic [CW-1:0]   c_LAST = CW'(XLEN - 1);

  logic [XLEN-1:0] r_q;     // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] r_r;     // partial remainder
  logic [XLEN-1:0] r_d;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  // Trial subtraction: a non-negative difference means the quotient bit is 1
  always_comb begin
    w_shift = {r_r, r_q[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_d};
    w_ge    = ~w_diff[XLEN];
  end

  // Load on start, then XLEN restoring steps; done pulses after the last step
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_busy <= 1'b0;
      end else if (i_start) begin
        r_q    <= i_dividend;
        r_r    <= '0;
        r_d    <= i_divisor;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_q   <= {r_q[XLEN-2:0], w_ge};
        r_r   <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_q;
  assign o_rem  = r_r;

endmodule
`default_nettype wire

// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : execute_muldiv
//  Brief    : RV32M multiply/divide unit for the execute stage; stalls the
//             front end until the result is ready
//  Revision : 1.0 - initial release
// ============================================================================
module execute_muldiv
  import muldiv_defs::*;
#(
  parameter int XLEN     = 32,
  parameter bit DIV_FAST = 1'b1
) (
  input  wire logic        CLK,
  input  wire logic        RES,
  execute_muldiv_if.slave  md
);
  md_state_t       r_state;
  md_state_t       w_next;

  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  logic            w_accept;
  logic            w_div_start;
  logic            w_stall;
  logic            w_valid;

  logic            w_in_signed;
  logic            w_in_special;
  logic [XLEN-1:0] w_in_a_mag;
  logic [XLEN-1:0] w_in_b_mag;
  logic [XLEN-1:0] w_fast_result;

  logic            w_a_sext;
  logic            w_b_sext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_mul_result;

  logic            w_div_done;
  logic [XLEN-1:0] w_div_q;
  logic [XLEN-1:0] w_div_r;
  logic [XLEN-1:0] w_div_result;

  // Applies operand signs to unsigned magnitudes; x/0 bypasses the sign rules
  function automatic logic [XLEN-1:0] div_fix(
    input logic            is_signed,
    input logic            is_rem,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag
  );
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    sa = is_signed & a[XLEN-1];
    sb = is_signed & b[XLEN-1];
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = (sa ^ sb) ? -q_mag : q_mag;
      r = sa ? -r_mag : r_mag;
    end
    return is_rem ? r : q;
  endfunction

  // Incoming-operand decode: magnitudes for the divider and the 1-cycle cases.
  // Signed overflow maps naturally: |MIN|/1 = MIN, sign fix leaves MIN.
  always_comb begin
    w_in_signed  = ~md.MD_funct3[0];
    w_in_a_mag   = (w_in_signed & md.MD_rs1[XLEN-1]) ? -md.MD_rs1 : md.MD_rs1;
    w_in_b_mag   = (w_in_signed & md.MD_rs2[XLEN-1]) ? -md.MD_rs2 : md.MD_rs2;
    w_in_special = (md.MD_rs2 == '0) |
                   (w_in_signed & (md.MD_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &
                    (md.MD_rs2 == '1));
    w_fast_result = div_fix(w_in_signed, md.MD_funct3[1], md.MD_rs1, md.MD_rs2,
                            w_in_a_mag, '0);
  end

  // Multiplier on latched operands; extending to 2*XLEN keeps the low
  // 2*XLEN bits of the product exact for every sign combination.
  always_comb begin
    w_a_sext     = (r_f3[1:0] != 2'b11) & r_a[XLEN-1];
    w_b_sext     = (r_f3[1:0] == 2'b01) & r_b[XLEN-1];
    w_prod       = {{XLEN{w_a_sext}}, r_a} * {{XLEN{w_b_sext}}, r_b};
    case (r_f3)
      F3_MUL:  w_mul_result = w_prod[XLEN-1:0];
      default: w_mul_result = w_prod[2*XLEN-1:XLEN];
    endcase
    w_div_result = div_fix(~r_f3[0], r_f3[1], r_a, r_b, w_div_q, w_div_r);
  end

  div_serial #(
    .XLEN       (XLEN)
  ) u_div (
    .CLK        (CLK),
    .RES        (RES),
    .i_start    (w_div_start),
    .i_abort    (md.MD_flush),
    .i_dividend (w_in_a_mag),
    .i_divisor  (w_in_b_mag),
    .o_done     (w_div_done),
    .o_quot     (w_div_q),
    .o_rem      (w_div_r)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RES) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, accept/stall/valid; DONE accepts like IDLE for back-to-back ops
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_div_start = 1'b0;
    w_stall     = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_valid = (r_state == S_DONE);
        w_stall = md.MD_start;
        w_next  = S_IDLE;
        if (md.MD_start) begin
          w_accept = 1'b1;
          if (!md.MD_funct3[2]) begin
            w_next = S_MUL;
          end else if (DIV_FAST && w_in_special) begin
            w_next = S_DONE;
          end else begin
            w_next      = S_DIV;
            w_div_start = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_stall = 1'b1;
        w_next  = S_DONE;
      end
      S_DIV: begin
        w_stall = 1'b1;
        if (w_div_done) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    if (md.MD_flush) begin
      w_next      = S_IDLE;
      w_accept    = 1'b0;
      w_div_start = 1'b0;
    end
  end

  // Operand latch at accept; result/rd update only on the edge entering DONE
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (w_accept) begin
      r_f3 <= md.MD_funct3;
      r_a  <= md.MD_rs1;
      r_b  <= md.MD_rs2;
      r_rd <= md.MD_rd;
      if (w_next == S_DONE) begin
        r_result <= w_fast_result;
        r_rd_out <= md.MD_rd;
      end
    end else if (w_next == S_DONE) begin
      r_result <= (r_state == S_MUL) ? w_mul_result : w_div_result;
      r_rd_out <= r_rd;
    end
  end

  assign md.MD_stall  = w_stall;
  assign md.MD_valid  = w_valid;
  assign md.MD_result = r_result;
  assign md.MD_rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_muldiv
//  Brief    : Self-checking bench for execute_muldiv with a behavioural model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  execute_muldiv_if #(.XLEN(32)) md_if();

  execute_muldiv #(
    .XLEN     (32),
    .DIV_FAST (1'b1)
  ) dut (
    .CLK (clk),
    .RES (res),
    .md  (md_if)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  localparam logic [31:0] MINV = 32'h8000_0000;

  // Architectural result of an RV32M op, from plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int          ia;
    int          ib;
    longint      p;
    logic [63:0] pu;
    logic [31:0] r;
    ia = $signed(a);
    ib = $signed(b);
    r  = '0;
    case (f3)
      3'd0: r = a * b;
      3'd1: begin p = longint'(ia) * longint'(ib); r = p[63:32]; end
      3'd2: begin p = longint'(ia) * longint'({32'd0, b}); r = p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                ((a == MINV && b == 32'hFFFF_FFFF) ? MINV : 32'(ia / ib));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                ((a == MINV && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3 < 3'd4) return 2;
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return MINV;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
    md_if.MD_start  = 1'b1;
    md_if.MD_funct3 = f3;
    md_if.MD_rs1    = a;
    md_if.MD_rs2    = b;
    md_if.MD_rd     = rd;
  endtask

  // Issue one op for a single cycle, then watch stall/valid/result/rd
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input string name);
    logic [31:0] exp_r;
    int          exp_lat;
    int          cyc;
    bit          got;
    bit          stall_ok;
    exp_r   = ref_result(f3, a, b);
    exp_lat = ref_latency(f3, a, b);
    @(posedge clk); #1;
    drive_start(f3, a, b, rd);
    @(negedge clk);
    checks++;
    if (md_if.MD_stall !== 1'b1) begin
      failures++;
      $display("FAIL %s_stall_at_start: got %b expected 1", name, md_if.MD_stall);
    end
    cyc = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        md_if.MD_start  = 1'b0;
        md_if.MD_rs1    = $urandom;
        md_if.MD_rs2    = $urandom;
        md_if.MD_funct3 = 3'($urandom);
        md_if.MD_rd     = 5'($urandom);
      end
      cyc++;
      @(negedge clk);
      if (md_if.MD_valid === 1'b1) got = 1'b1;
      else if (md_if.MD_stall !== 1'b1) stall_ok = 1'b0;
    end
    checks++;
    if (!got || cyc != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d (valid=%b) expected %0d", name, cyc, got, exp_lat);
    end
    if (got) begin
      checks++;
      if (md_if.MD_result !== exp_r) begin
        failures++;
        $display("FAIL %s_result: got %h expected %h", name, md_if.MD_result, exp_r);
      end
      checks++;
      if (md_if.MD_rd_out !== rd) begin
        failures++;
        $display("FAIL %s_rd: got %0d expected %0d", name, md_if.MD_rd_out, rd);
      end
      checks++;
      if (md_if.MD_stall !== 1'b0) begin
        failures++;
        $display("FAIL %s_stall_at_valid: got %b expected 0", name, md_if.MD_stall);
      end
    end
    checks++;
    if (!stall_ok) begin
      failures++;
      $display("FAIL %s_stall_hold: stall dropped before valid, expected held high", name);
    end
    last_res = exp_r;
    last_rd  = rd;
  endtask

  task automatic test_reset();
    res = 1'b1;
    drive_start(3'd0, 32'd3, 32'd4, 5'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (md_if.MD_valid !== 1'b0 || md_if.MD_result !== 32'd0 || md_if.MD_rd_out !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b result=%h rd=%0d expected 0/0/0",
               md_if.MD_valid, md_if.MD_result, md_if.MD_rd_out);
    end
    md_if.MD_start = 1'b0;
    #1;
    checks++;
    if (md_if.MD_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b expected 0", md_if.MD_stall);
    end
    @(posedge clk); #1;
    res = 1'b0;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  "mul");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  "mulh");
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  "div");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  "rem");
    run_op(3'd5, 32'd100,        32'd7,         5'd7,  "divu");
    run_op(3'd5, 32'd5,          32'd0,         5'd8,  "divu_by0");
    run_op(3'd7, 32'd5,          32'd0,         5'd9,  "remu_by0");
    run_op(3'd4, MINV,           32'hFFFF_FFFF, 5'd10, "div_ovf");
    run_op(3'd6, MINV,           32'hFFFF_FFFF, 5'd11, "rem_ovf");
    run_op(3'd6, 32'hFFFF_FFF3,  32'd0,         5'd12, "rem_by0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom), "rand");
    end
  endtask

  task automatic test_flush();
    bit seen;
    @(posedge clk); #1;
    drive_start(3'd4, 32'd1000, 32'd7, 5'd20);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      md_if.MD_start = 1'b0;
    end
    md_if.MD_flush = 1'b1;
    @(posedge clk); #1;
    md_if.MD_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (md_if.MD_stall !== 1'b0 || md_if.MD_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: got stall=%b valid=%b expected 0/0",
               md_if.MD_stall, md_if.MD_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_if.MD_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL flush_no_valid: got a valid after flush, expected none");
    end
    checks++;
    if (md_if.MD_result !== last_res || md_if.MD_rd_out !== last_rd) begin
      failures++;
      $display("FAIL flush_hold: got %h/%0d expected %h/%0d",
               md_if.MD_result, md_if.MD_rd_out, last_res, last_rd);
    end
    // start and flush together: the op must not be taken
    @(posedge clk); #1;
    drive_start(3'd0, 32'd5, 32'd6, 5'd21);
    md_if.MD_flush = 1'b1;
    @(posedge clk); #1;
    md_if.MD_start = 1'b0;
    md_if.MD_flush = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    checks++;
    if (md_if.MD_stall !== 1'b0) begin
      failures++;
      $display("FAIL start_flush_stall: got %b expected 0", md_if.MD_stall);
    end
    for (int c = 0; c < 5; c++) begin
      if (md_if.MD_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL start_flush_valid: got a valid, expected none");
    end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    run_op(3'd0, 32'd12345, 32'd678, 5'd17, "pre_reset_mul");
    @(posedge clk); #1;
    drive_start(3'd5, 32'd999_999, 32'd13, 5'd18);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      md_if.MD_start = 1'b0;
    end
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    checks++;
    if (md_if.MD_valid !== 1'b0 || md_if.MD_stall !== 1'b0 ||
        md_if.MD_result !== 32'd0 || md_if.MD_rd_out !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_div: got valid=%b stall=%b result=%h rd=%0d expected 0/0/0/0",
               md_if.MD_valid, md_if.MD_stall, md_if.MD_result, md_if.MD_rd_out);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_if.MD_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_div_valid: got a valid after reset, expected none");
    end
    last_res = '0;
    last_rd  = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea;
    logic [31:0] eb;
    ea = ref_result(3'd0, 32'd11, 32'd13);
    eb = ref_result(3'd1, 32'hF000_0000, 32'h0000_0100);
    @(posedge clk); #1;
    drive_start(3'd0, 32'd11, 32'd13, 5'd25);
    @(posedge clk); #1;
    md_if.MD_start = 1'b0;
    @(posedge clk); #1;
    drive_start(3'd1, 32'hF000_0000, 32'h0000_0100, 5'd26);
    @(negedge clk);
    checks++;
    if (md_if.MD_valid !== 1'b1 || md_if.MD_result !== ea ||
        md_if.MD_rd_out !== 5'd25 || md_if.MD_stall !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got valid=%b result=%h rd=%0d stall=%b expected 1/%h/25/1",
               md_if.MD_valid, md_if.MD_result, md_if.MD_rd_out, md_if.MD_stall, ea);
    end
    @(posedge clk); #1;
    md_if.MD_start = 1'b0;
    @(negedge clk);
    checks++;
    if (md_if.MD_valid !== 1'b0 || md_if.MD_stall !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: got valid=%b stall=%b expected 0/1",
               md_if.MD_valid, md_if.MD_stall);
    end
    @(negedge clk);
    checks++;
    if (md_if.MD_valid !== 1'b1 || md_if.MD_result !== eb || md_if.MD_rd_out !== 5'd26) begin
      failures++;
      $display("FAIL b2b_second: got valid=%b result=%h rd=%0d expected 1/%h/26",
               md_if.MD_valid, md_if.MD_result, md_if.MD_rd_out, eb);
    end
  endtask

  initial begin
    res             = 1'b1;
    md_if.MD_start  = 1'b0;
    md_if.MD_flush  = 1'b0;
    md_if.MD_funct3 = '0;
    md_if.MD_rs1    = '0;
    md_if.MD_rs2    = '0;
    md_if.MD_rd     = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid_div();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
